// File: rtl/dc_wm_embed.sv
// Watermark embedder: turns a per-block signed DC difference into a clamped DC correction that
// pushes the difference past +/-THRESH in the direction of the current payload bit.
module dc_wm_embed #(
   parameter int PAYLOAD_W = 32,
   parameter int THRESH    = 16,
   parameter int MAX_ADJ   = 64,
   parameter int CNT_W     = 16
) (
   input  logic                  pclk,
   input  logic                  rst_n,
   input  logic                  i_pd,
   input  logic signed [12:0]    diff0,
   input  logic                  frame_start,
   input  logic                  wm_load,
   input  logic [PAYLOAD_W-1:0]  wm_word,
   output logic                  o_adj,
   output logic signed [13:0]    adj,
   output logic                  o_bit,
   output logic                  o_active,
   output logic [CNT_W-1:0]      blk_cnt
);

   localparam int PTR_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PAYLOAD_W - 1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic signed [13:0] THR_P = 14'(THRESH);
   localparam logic signed [13:0] THR_N = 14'(-THRESH);
   localparam logic signed [13:0] MAX_P = 14'(MAX_ADJ);
   localparam logic signed [13:0] MAX_N = 14'(-MAX_ADJ);
   localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                 state_r, state_nxt_s;
   logic [PAYLOAD_W-1:0]   payload_r;
   logic [PTR_W-1:0]       ptr_r, ptr_nxt_s, cur_idx_s;
   logic                   run_s, cur_bit_s;
   logic signed [13:0]     diff_ext_s, need_s;
   logic                   s1_vld_r, s1_bit_r, s1_run_r;
   logic signed [13:0]     s1_need_r;
   logic [CNT_W-1:0]       cnt_nxt_s;

   function automatic logic signed [13:0] calc_need(input logic b, input logic signed [13:0] d);
      logic signed [13:0] n;
      n = 14'sd0;
      if (b) begin
         if (d < THR_P) n = THR_P - d;
         else           n = 14'sd0;
      end else begin
         if (d > THR_N) n = THR_N - d;
         else           n = 14'sd0;
      end
      return n;
   endfunction

   function automatic logic signed [13:0] clamp_adj(input logic signed [13:0] n);
      logic signed [13:0] r;
      r = n;
      if (n > MAX_P)      r = MAX_P;
      else if (n < MAX_N) r = MAX_N;
      else                r = n;
      return r;
   endfunction

   // Mode transitions: the first payload load starts embedding, reloads keep running.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (wm_load) state_nxt_s = ST_RUN;
            else         state_nxt_s = ST_IDLE;
         end
         ST_RUN:  state_nxt_s = ST_RUN;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Stage-1 payload bit selection and correction demand; a frame_start rewinds to bit 0 at once.
   always_comb begin
      run_s      = (state_r == ST_RUN);
      cur_idx_s  = frame_start ? PTR_ZERO : ptr_r;
      diff_ext_s = {diff0[12], diff0};
      if (run_s) begin
         cur_bit_s = payload_r[cur_idx_s];
         need_s    = calc_need(payload_r[cur_idx_s], diff_ext_s);
      end else begin
         cur_bit_s = 1'b0;
         need_s    = 14'sd0;
      end
   end

   // Pointer update: load/frame rewinds win; a consumed bit otherwise advances with wrap.
   always_comb begin
      ptr_nxt_s = ptr_r;
      if (wm_load) begin
         ptr_nxt_s = PTR_ZERO;
      end else if (i_pd && run_s) begin
         if (cur_idx_s == PTR_LAST) ptr_nxt_s = PTR_ZERO;
         else                       ptr_nxt_s = cur_idx_s + PTR_ONE;
      end else if (frame_start) begin
         ptr_nxt_s = PTR_ZERO;
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   // Block counter: a frame start clears it even if a block completes on the same edge.
   always_comb begin
      cnt_nxt_s = blk_cnt;
      if (frame_start) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (s1_vld_r && s1_run_r && (blk_cnt != CNT_MAX)) begin
         cnt_nxt_s = blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_nxt_s = blk_cnt;
      end
   end

   // Control state: mode, payload and pointer.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         payload_r <= {PAYLOAD_W{1'b0}};
         ptr_r     <= PTR_ZERO;
      end else begin
         state_r   <= state_nxt_s;
         ptr_r     <= ptr_nxt_s;
         if (wm_load) payload_r <= wm_word;
      end
   end

   // Two-stage pipeline: demand capture, then clamp and registered outputs.
   always_ff @(posedge pclk) begin
      if (!rst_n) begin
         s1_vld_r  <= 1'b0;
         s1_bit_r  <= 1'b0;
         s1_run_r  <= 1'b0;
         s1_need_r <= 14'sd0;
         o_adj     <= 1'b0;
         adj       <= 14'sd0;
         o_bit     <= 1'b0;
         o_active  <= 1'b0;
         blk_cnt   <= {CNT_W{1'b0}};
      end else begin
         s1_vld_r <= i_pd;
         if (i_pd) begin
            s1_bit_r  <= cur_bit_s;
            s1_run_r  <= run_s;
            s1_need_r <= need_s;
         end
         o_adj    <= s1_vld_r;
         if (s1_vld_r) begin
            adj   <= clamp_adj(s1_need_r);
            o_bit <= s1_bit_r;
         end
         o_active <= (state_nxt_s == ST_RUN);
         blk_cnt  <= cnt_nxt_s;
      end
   end

endmodule

// File: tb/tb_dc_wm_embed.sv
// Directed bench for dc_wm_embed (PAYLOAD_W=32, THRESH=16, MAX_ADJ=64, CNT_W=16) with
// hand-computed expected corrections, payload bits and counter values.
module tb_dc_wm_embed;

   logic               pclk = 1'b0;
   logic               rst_n;
   logic               i_pd;
   logic signed [12:0] diff0;
   logic               frame_start;
   logic               wm_load;
   logic [31:0]        wm_word;
   logic               o_adj;
   logic signed [13:0] adj;
   logic               o_bit;
   logic               o_active;
   logic [15:0]        blk_cnt;

   int checks = 0;
   int errors = 0;

   dc_wm_embed #(.PAYLOAD_W(32), .THRESH(16), .MAX_ADJ(64), .CNT_W(16)) dut (
      .pclk(pclk), .rst_n(rst_n), .i_pd(i_pd), .diff0(diff0),
      .frame_start(frame_start), .wm_load(wm_load), .wm_word(wm_word),
      .o_adj(o_adj), .adj(adj), .o_bit(o_bit), .o_active(o_active), .blk_cnt(blk_cnt)
   );

   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One isolated strobe; checks nothing appears early, then the pulse contents.
   task automatic block(input string tag, input int d, input int exp_adj, input logic exp_bit);
      @(negedge pclk);
      i_pd  = 1'b1;
      diff0 = 13'(d);
      @(negedge pclk);
      i_pd  = 1'b0;
      diff0 = 13'h0aaa;
      chk({tag, "_early"}, o_adj, 0);
      @(negedge pclk);
      chk({tag, "_valid"}, o_adj, 1);
      chk({tag, "_adj"}, adj, exp_adj);
      chk({tag, "_bit"}, o_bit, exp_bit);
   endtask

   initial begin
      logic exp_b;
      rst_n = 1'b0; i_pd = 1'b0; diff0 = 13'sd0;
      frame_start = 1'b0; wm_load = 1'b0; wm_word = 32'h0;

      // reset held three cycles with strobes toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         chk("rst_o_adj", o_adj, 0);
         chk("rst_adj", adj, 0);
         chk("rst_o_bit", o_bit, 0);
         chk("rst_active", o_active, 0);
         chk("rst_cnt", blk_cnt, 0);
         i_pd  = (i != 1);
         diff0 = 13'sd100;
      end
      @(negedge pclk);
      rst_n = 1'b1; i_pd = 1'b0;
      chk("rst_flush0", o_adj, 0);
      @(negedge pclk);
      chk("rst_flush1", o_adj, 0);

      // idle pass-through
      block("idle", -100, 0, 1'b0);
      chk("idle_active", o_active, 0);
      chk("idle_cnt", blk_cnt, 0);
      @(negedge pclk);
      chk("idle_pulse_end", o_adj, 0);

      // load payload 1: bits 1,0,0
      @(negedge pclk);
      wm_load = 1'b1; wm_word = 32'h1;
      @(negedge pclk);
      wm_load = 1'b0;
      chk("load_active", o_active, 1);
      block("b1_d5", 5, 11, 1'b1);
      block("b0_d5", 5, -21, 1'b0);
      block("b0_dneg", -2047, 0, 1'b0);
      chk("run_cnt3", blk_cnt, 3);

      // clamp both directions
      @(negedge pclk);
      wm_load = 1'b1; wm_word = 32'h1;
      @(negedge pclk);
      wm_load = 1'b0;
      block("clamp_pos", -2047, 64, 1'b1);
      block("clamp_neg", 4095, -64, 1'b0);

      // wrap: 33 back-to-back strobes with diff0=0
      @(negedge pclk);
      wm_load = 1'b1; frame_start = 1'b1; wm_word = 32'h8000_0001;
      @(negedge pclk);
      wm_load = 1'b0; frame_start = 1'b0;
      chk("wrap_cnt_clr", blk_cnt, 0);
      for (int i = 0; i < 35; i++) begin
         @(negedge pclk);
         if (i >= 2) begin
            exp_b = ((i - 2) == 0) || ((i - 2) == 31) || ((i - 2) == 32);
            chk("wrap_valid", o_adj, 1);
            chk("wrap_bit", o_bit, exp_b);
            chk("wrap_adj", adj, exp_b ? 16 : -16);
         end
         i_pd  = (i < 33);
         diff0 = 13'sd0;
      end
      @(negedge pclk);
      chk("wrap_end", o_adj, 0);
      chk("wrap_cnt33", blk_cnt, 33);

      // frame_start with strobe in same cycle (pointer currently 1)
      @(negedge pclk);
      frame_start = 1'b1; i_pd = 1'b1; diff0 = 13'sd0;
      @(negedge pclk);
      frame_start = 1'b0; i_pd = 1'b0;
      chk("frame_cnt_clr", blk_cnt, 0);
      @(negedge pclk);
      chk("frame_valid", o_adj, 1);
      chk("frame_bit", o_bit, 1);
      chk("frame_adj", adj, 16);
      chk("frame_cnt1", blk_cnt, 1);
      block("frame_next", 0, -16, 1'b0);
      chk("frame_cnt2", blk_cnt, 2);

      // reset one cycle after a strobe discards it
      @(negedge pclk);
      i_pd = 1'b1; diff0 = 13'sd0;
      @(negedge pclk);
      i_pd = 1'b0; rst_n = 1'b0;
      @(negedge pclk);
      rst_n = 1'b1;
      chk("rstc_o_adj0", o_adj, 0);
      chk("rstc_active", o_active, 0);
      chk("rstc_cnt", blk_cnt, 0);
      @(negedge pclk);
      chk("rstc_o_adj1", o_adj, 0);
      @(negedge pclk);
      chk("rstc_o_adj2", o_adj, 0);

      // load and strobe together from idle
      @(negedge pclk);
      wm_load = 1'b1; wm_word = 32'h1; i_pd = 1'b1; diff0 = 13'sd0;
      @(negedge pclk);
      wm_load = 1'b0; i_pd = 1'b0;
      chk("ldc_early", o_adj, 0);
      @(negedge pclk);
      chk("ldc_valid", o_adj, 1);
      chk("ldc_adj", adj, 0);
      chk("ldc_bit", o_bit, 0);
      chk("ldc_active", o_active, 1);
      block("ldc_next", 0, 16, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
